// File: rtl/trace_decoder.sv
// trace_decoder: turns CPU control-word/bus activity into per-instruction trace records held in a FIFO.
// Optional macro TRACE_CHECK_EN compiles in execute-step signature checking (drives rec_mismatch).
module trace_decoder #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] ctrl,
    input  logic [7:0]  bus,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [3:0]  rec_pc,
    output logic [3:0]  rec_op,
    output logic [3:0]  rec_arg,
    output logic [7:0]  rec_result,
    output logic        rec_halt,
    output logic        rec_mismatch,
    output logic [7:0]  drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [16:0] PC_OUT    = 17'h00002;
    localparam logic [16:0] PC_INC    = 17'h00004;
    localparam logic [16:0] A_READ    = 17'h00010;
    localparam logic [16:0] I_READ    = 17'h00100;
    localparam logic [16:0] MAR_READ  = 17'h00400;
    localparam logic [16:0] RAM_READ  = 17'h00800;
    localparam logic [16:0] RAM_WRITE = 17'h01000;
    localparam logic [16:0] OUT_EN    = 17'h10000;
    localparam logic [16:0] FETCH0_W  = PC_OUT | MAR_READ;
    localparam logic [16:0] FETCH1_W  = RAM_WRITE | I_READ | PC_INC;
    localparam logic [16:0] LOADS     = A_READ | RAM_READ | OUT_EN;

    typedef enum logic [1:0] {SYNC, FETCH1, EXEC, HALTED} state_t;

    state_t        r_state, w_next;
    logic          w_fetch0, w_fetch1, w_halt, w_load;
    logic          w_cap_pc, w_cap_ins, w_push, w_upd;
    logic [3:0]    r_pc, r_op, r_arg;
    logic [7:0]    r_result, w_result, r_drop;
    logic          w_mis;
    logic [21:0]   w_rec;
    logic [21:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_cnt;
    logic          w_pop, w_wr, w_drop;

    assign w_fetch0 = ctrl == FETCH0_W;
    assign w_fetch1 = ctrl == FETCH1_W;
    assign w_halt   = ctrl[0];
    assign w_load   = |(ctrl & LOADS);

    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= SYNC;
        else     r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            SYNC:    w_next = w_fetch0 ? FETCH1 : SYNC;
            FETCH1:  w_next = w_fetch1 ? EXEC : SYNC;
            EXEC:    w_next = w_halt ? HALTED : w_fetch0 ? FETCH1 : EXEC;
            HALTED:  w_next = ctrl == 17'd0 ? SYNC : HALTED;
            default: w_next = SYNC;
        endcase
    end

    always_comb begin
        w_cap_pc  = w_fetch0 && (r_state == SYNC || r_state == EXEC);
        w_cap_ins = w_fetch1 && r_state == FETCH1;
        w_push    = r_state == EXEC && (w_halt || w_fetch0);
        w_upd     = r_state == EXEC && w_load;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_pc     <= '0;
            r_op     <= '0;
            r_arg    <= '0;
            r_result <= '0;
        end else begin
            if (w_cap_pc) r_pc <= bus[3:0];
            if (w_cap_ins) begin
                r_op     <= bus[7:4];
                r_arg    <= bus[3:0];
                r_result <= '0;
            end else if (w_upd) r_result <= bus;
        end

`ifdef TRACE_CHECK_EN
    localparam logic [16:0] CLK_HLT   = 17'h00001;
    localparam logic [16:0] PC_JUMP   = 17'h00008;
    localparam logic [16:0] A_WRITE   = 17'h00020;
    localparam logic [16:0] B_READ    = 17'h00040;
    localparam logic [16:0] I_WRITE   = 17'h00200;
    localparam logic [16:0] ALU_OUT   = 17'h02000;
    localparam logic [16:0] ALU_SUB   = 17'h04000;
    localparam logic [16:0] ALU_FLAGS = 17'h08000;

    logic [2:0]  r_step;
    logic        r_mis, w_alt, w_bad;
    logic [16:0] w_sig;

    // r_step holds the index (2..6) of the word now on ctrl; 7 means all execute steps seen
    always_comb begin
        w_sig = '0;
        case (r_op)
            4'd1:       w_sig = r_step == 3'd2 ? I_WRITE | MAR_READ : r_step == 3'd3 ? RAM_WRITE | A_READ : 17'd0;
            4'd2, 4'd3: w_sig = r_step == 3'd2 ? I_WRITE | MAR_READ : r_step == 3'd3 ? RAM_WRITE | B_READ :
                                r_step == 3'd4 ? ALU_OUT | ALU_FLAGS | A_READ | (r_op == 4'd3 ? ALU_SUB : 17'd0) : 17'd0;
            4'd4:       w_sig = r_step == 3'd2 ? I_WRITE | MAR_READ : r_step == 3'd3 ? A_WRITE | RAM_READ : 17'd0;
            4'd5:       w_sig = r_step == 3'd2 ? I_WRITE | A_READ : 17'd0;
            4'd6, 4'd7, 4'd8: w_sig = r_step == 3'd2 ? I_WRITE | PC_JUMP : 17'd0;
            4'd14:      w_sig = r_step == 3'd2 ? A_WRITE | OUT_EN : 17'd0;
            4'd15:      w_sig = r_step == 3'd2 ? CLK_HLT : 17'd0;
            default:    w_sig = '0;
        endcase
    end

    // conditional jumps may leave step 2 idle when not taken
    assign w_alt = (r_op == 4'd7 || r_op == 4'd8) && r_step == 3'd2 && ctrl == 17'd0;
    assign w_bad = r_step != 3'd7 && ctrl != w_sig && !w_alt;
    assign w_mis = r_mis | (w_fetch0 ? r_step != 3'd7 : w_bad);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_step <= '0;
            r_mis  <= 1'b0;
        end else if (w_cap_ins) begin
            r_step <= 3'd2;
            r_mis  <= 1'b0;
        end else if (r_state == EXEC) begin
            r_step <= r_step + {2'd0, r_step != 3'd7};
            r_mis  <= r_mis | w_bad;
        end
`else
    assign w_mis = 1'b0;
`endif

    assign w_result = w_load ? bus : r_result;
    assign w_rec    = {r_pc, r_op, r_arg, w_result, w_halt, w_mis};

    assign rec_valid = r_cnt != '0;
    assign w_pop     = rec_valid && rec_ready;
    assign w_wr      = w_push && (r_cnt != FULL || w_pop);
    assign w_drop    = w_push && !w_wr;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_cnt  <= '0;
            r_drop <= '0;
        end else begin
            if (w_wr) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_pop);
            if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
        end

    always_ff @(posedge clk)
        if (w_wr) r_mem[r_wr] <= w_rec;

    // outputs read as zero whenever the FIFO is empty, including straight out of reset
    assign {rec_pc, rec_op, rec_arg, rec_result, rec_halt, rec_mismatch} = rec_valid ? r_mem[r_rd] : 22'd0;
    assign drop_cnt = r_drop;
endmodule

// File: tb/tb_trace_decoder.sv
// tb_trace_decoder: randomized instruction streams checked against an instruction-level record model.
// Follows TRACE_CHECK_EN the same way the design does.
module tb_trace_decoder;
    localparam int DEPTH = 4;
`ifdef TRACE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam logic [16:0] HLT = 17'h1, PC_OUT = 17'h2, PC_INC = 17'h4, PC_JUMP = 17'h8;
    localparam logic [16:0] A_READ = 17'h10, A_WRITE = 17'h20, B_READ = 17'h40, I_READ = 17'h100;
    localparam logic [16:0] I_WRITE = 17'h200, MAR_READ = 17'h400, RAM_READ = 17'h800, RAM_WRITE = 17'h1000;
    localparam logic [16:0] ALU_OUT = 17'h2000, ALU_SUB = 17'h4000, ALU_FLAGS = 17'h8000, OUT_EN = 17'h10000;
    localparam logic [16:0] F0 = PC_OUT | MAR_READ, F1 = RAM_WRITE | I_READ | PC_INC;
    localparam logic [16:0] LOADS = A_READ | RAM_READ | OUT_EN;

    typedef struct packed {
        logic [3:0] pc, op, arg;
        logic [7:0] res;
        logic       halt, mis;
    } rec_t;

    logic        clk = 1'b0, rst = 1'b1, rec_ready = 1'b0;
    logic [16:0] ctrl = '0;
    logic [7:0]  bus = '0;
    logic        rec_valid, rec_halt, rec_mismatch;
    logic [3:0]  rec_pc, rec_op, rec_arg;
    logic [7:0]  rec_result, drop_cnt;
    logic [21:0] dut_rec;

    rec_t q[$];
    rec_t cur;
    bit   open;
    int   drops, rdy_mode;
    int   n_checks = 0, n_errs = 0;

    trace_decoder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ctrl(ctrl), .bus(bus),
        .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_pc(rec_pc), .rec_op(rec_op), .rec_arg(rec_arg), .rec_result(rec_result),
        .rec_halt(rec_halt), .rec_mismatch(rec_mismatch), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;
    assign dut_rec = {rec_pc, rec_op, rec_arg, rec_result, rec_halt, rec_mismatch};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] sig(input logic [3:0] op, input int k, input bit taken);
        logic [16:0] s2, s3, s4;
        s2 = '0; s3 = '0; s4 = '0;
        case (op)
            4'd1: begin s2 = I_WRITE | MAR_READ; s3 = RAM_WRITE | A_READ; end
            4'd2, 4'd3: begin
                s2 = I_WRITE | MAR_READ;
                s3 = RAM_WRITE | B_READ;
                s4 = ALU_OUT | ALU_FLAGS | A_READ | (op == 4'd3 ? ALU_SUB : 17'd0);
            end
            4'd4: begin s2 = I_WRITE | MAR_READ; s3 = A_WRITE | RAM_READ; end
            4'd5: s2 = I_WRITE | A_READ;
            4'd6: s2 = I_WRITE | PC_JUMP;
            4'd7, 4'd8: s2 = taken ? I_WRITE | PC_JUMP : 17'd0;
            4'd14: s2 = A_WRITE | OUT_EN;
            4'd15: s2 = HLT;
            default: ;
        endcase
        return k == 2 ? s2 : k == 3 ? s3 : k == 4 ? s4 : 17'd0;
    endfunction

    // compare the visible FIFO head, then drive one word and apply its effect to the model
    task automatic cyc(input logic [16:0] c, input logic [7:0] b, input bit push);
        @(negedge clk);
        check("valid", rec_valid, q.size() > 0);
        if (q.size() > 0) check("rec", dut_rec, q[0]);
        check("drop_cnt", drop_cnt, drops);
        ctrl = c;
        bus = b;
        rec_ready = rdy_mode == 1 ? 1'b1 : rdy_mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
        if (rec_ready && q.size() > 0) void'(q.pop_front());
        if (push) begin
            if (q.size() < DEPTH) q.push_back(cur);
            else if (drops < 255) drops++;
            open = 0;
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1 check("rst_valid", rec_valid, 0);
        check("rst_rec", dut_rec, 0);
        check("rst_drop", drop_cnt, 0);
        q.delete();
        drops = 0;
        open = 0;
        ctrl = '0;
        bus = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic instr(input logic [3:0] pc, input logic [3:0] op, input logic [3:0] arg, input int nsteps,
                         input int bad_step, input int bad_bit, input bit taken, input int fbus);
        logic [16:0] w;
        logic [7:0]  b;
        int          bi;
        cyc(F0, {4'($urandom), pc}, open);
        cyc(F1, {op, arg}, 0);
        cur = {pc, op, arg, 8'd0, 2'b00};
        open = 1;
        for (int k = 2; k <= nsteps + 1; k++) begin
            w = sig(op, k, taken);
            if (k == bad_step) begin
                bi = bad_bit >= 0 ? bad_bit : $urandom_range(2, 16);
                w[bi] = ~w[bi];
                cur.mis = CHK;
            end
            b = fbus >= 0 ? 8'(fbus) : 8'($urandom);
            if ((w & LOADS) != 0) cur.res = b;
            if (w[0]) begin
                cur.halt = 1'b1;
                cyc(w, b, 1);
                cyc(F0, 8'($urandom), 0);
                cyc(F1, 8'($urandom), 0);
                repeat (3) cyc(17'($urandom) | PC_OUT, 8'($urandom), 0);
                cyc(17'd0, 8'($urandom), 0);
                return;
            end
            cyc(w, b, 0);
        end
        if (nsteps < 5) cur.mis = CHK;
    endtask

    task automatic flush();
        if (open) cyc(F0, 8'($urandom), 1);
        cyc(17'd0, 8'($urandom), 0);
    endtask

    task automatic drain(input int n);
        rdy_mode = 1;
        repeat (n) cyc(17'd0, 8'($urandom), 0);
    endtask

    initial begin
        logic [16:0] c;
        logic [3:0]  op;
        int          ns, bad;
        rdy_mode = 0;
        do_reset();
        repeat (12) begin
            c = 17'($urandom);
            cyc(c == F0 ? 17'd0 : c, 8'($urandom), 0);
        end
        instr(4'h3, 4'h1, 4'hE, 5, 0, -1, 0, 'h42);
        instr(4'h5, 4'h3, 4'h2, 5, 4, 14, 0, -1);
        instr(4'h6, 4'h2, 4'h1, 5, 0, -1, 0, -1);
        instr(4'h7, 4'hF, 4'h0, 5, 0, -1, 0, -1);
        instr(4'h8, 4'h7, 4'h3, 5, 0, -1, 0, -1);
        instr(4'h9, 4'h7, 4'h4, 5, 0, -1, 1, -1);
        instr(4'hA, 4'h8, 4'h5, 5, 0, -1, 0, -1);
        instr(4'hB, 4'h8, 4'h6, 5, 0, -1, 1, -1);
        instr(4'hC, 4'h4, 4'h9, 5, 0, -1, 0, -1);
        instr(4'hD, 4'hE, 4'h0, 5, 0, -1, 0, -1);
        instr(4'h1, 4'h2, 4'h0, 2, 0, -1, 0, -1);
        instr(4'h2, 4'h5, 4'h3, 5, 0, -1, 0, -1);
        flush();
        drain(DEPTH + 2);

        do_reset();
        rdy_mode = 2;
        for (int i = 0; i < DEPTH + 3; i++) instr(4'(i), 4'($urandom_range(0, 6)), 4'($urandom), 5, 0, -1, 1, -1);
        flush();
        @(negedge clk);
        check("drop_cnt_bp", drop_cnt, 3);
        drain(DEPTH + 2);

        rdy_mode = 2;
        instr(4'h2, 4'h5, 4'h1, 5, 0, -1, 0, -1);
        cyc(F0, 8'h09, 1);
        cyc(F1, 8'h2A, 0);
        cur = {4'h9, 8'h2A, 8'd0, 2'b00};
        open = 1;
        cyc(sig(4'h2, 2, 0), 8'($urandom), 0);
        cyc(sig(4'h2, 3, 0), 8'($urandom), 0);
        do_reset();
        rdy_mode = 0;
        instr(4'h5, 4'h2, 4'h7, 5, 0, -1, 0, -1);
        flush();
        drain(DEPTH + 2);

        rdy_mode = 0;
        repeat (80) begin
            op  = 4'($urandom);
            ns  = $urandom_range(0, 5) == 0 ? $urandom_range(1, 4) : 5;
            bad = $urandom_range(0, 4) == 0 ? $urandom_range(2, 6) : 0;
            instr(4'($urandom), op, 4'($urandom), ns, bad, -1, 1'($urandom), -1);
        end
        flush();
        drain(DEPTH + 2);

        do_reset();
        rdy_mode = 2;
        repeat (300) instr(4'($urandom), 4'h0, 4'($urandom), 5, 0, -1, 0, -1);
        flush();
        @(negedge clk);
        check("drop_cnt_sat", drop_cnt, 255);
        drain(DEPTH + 2);
        cyc(17'd0, 8'd0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule
